// File: rtl/ram_access_controller_pkg.sv
// Shared types and constants for the RAM access controller and its write pacer.
package ram_ctrl_pkg;

  localparam int NB_STATE      = 3;
  localparam int NB_WORD_COUNT = 7;
  localparam int WORD_STRIDE   = 4;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_WAIT  = 3'd1,
    ST_LOAD_PULSE = 3'd2,
    ST_LOAD_GAP   = 3'd3,
    ST_DUMP_ADDR  = 3'd4,
    ST_DUMP_WAIT  = 3'd5,
    ST_DUMP_OUT   = 3'd6
  } state_t;

  function automatic logic [NB_WORD_COUNT-1:0] clamp_count(
    input logic [NB_WORD_COUNT-1:0] req,
    input logic [NB_WORD_COUNT-1:0] limit
  );
    return (req > limit) ? limit : req;
  endfunction

endpackage

// File: rtl/ram_access_controller_pacer.sv
// Write pacer: one-cycle write_data_next pulse followed by a WRITE_GAP idle window.
module ram_write_pacer #(
  parameter int WRITE_GAP = 6
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_start,
  output logic o_pulse,
  output logic o_busy
);

  localparam int NB_GAP = $clog2(WRITE_GAP + 2);

  logic              pulse_q, pulse_d;
  logic [NB_GAP-1:0] gap_q, gap_d;

  always_comb begin
    pulse_d = i_start;
    gap_d   = gap_q;
    if (i_start)
      gap_d = NB_GAP'(WRITE_GAP);
    else if (!pulse_q && gap_q != '0)
      gap_d = gap_q - NB_GAP'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pulse_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
    end
  end

  assign o_pulse = pulse_q;
  // Drops during the final gap cycle so the caller's FSM leaves exactly on time.
  assign o_busy  = pulse_q || (gap_q > NB_GAP'(1));

endmodule

// File: rtl/ram_access_controller.sv
// Arbitrates ram_memory between loader, dumper and CPU fetch.
// Optional RAM_ACCESS_STATS_EN adds o_stall_cycles (saturating stall-cycle counter).
module ram_access_controller
  import ram_ctrl_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDRESS   = 8,
  parameter int RAM_DEPTH    = 256,
  parameter int WRITE_GAP    = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_load_start,
  input  logic                     i_load_end,
  input  logic [NB_DATA-1:0]       i_load_data,
  input  logic                     i_load_valid,
  output logic                     o_load_ready,
  output logic                     o_load_full,
  input  logic                     i_dump_start,
  input  logic [NB_WORD_COUNT-1:0] i_dump_count,
  output logic [NB_DATA-1:0]       o_dump_data,
  output logic                     o_dump_valid,
  input  logic                     i_dump_ready,
  output logic                     o_dump_done,
  input  logic [NB_ADDRESS-1:0]    i_fetch_address,
  output logic [NB_DATA-1:0]       o_fetch_data,
  output logic                     o_fetch_stall,
  output logic [NB_WORD_COUNT-1:0] o_word_count,
  output logic [NB_ADDRESS-1:0]    o_ram_read_address,
  output logic [NB_DATA-1:0]       o_ram_write_data,
  output logic                     o_ram_write_enable,
  output logic                     o_ram_write_data_next,
  input  logic [NB_DATA-1:0]       i_ram_read_data
`ifdef RAM_ACCESS_STATS_EN
  ,output logic [15:0]             o_stall_cycles
`endif
);

  localparam logic [NB_WORD_COUNT-1:0] WORDS = NB_WORD_COUNT'(RAM_DEPTH / WORD_STRIDE);
  localparam int NB_LAT = $clog2(READ_LATENCY + 2);

  state_t                     state_q, state_d;
  logic [NB_WORD_COUNT-1:0]   word_cnt_q, word_cnt_d;
  logic [NB_WORD_COUNT-1:0]   dump_idx_q, dump_idx_d;
  logic [NB_WORD_COUNT-1:0]   dump_cnt_q, dump_cnt_d;
  logic [NB_LAT-1:0]          lat_q, lat_d;
  logic                       end_seen_q, end_seen_d;
  logic [NB_DATA-1:0]         wdata_q, wdata_d;
  logic [NB_DATA-1:0]         dump_data_q, dump_data_d;
  logic                       dump_valid_q, dump_valid_d;
  logic                       dump_done_q, dump_done_d;
  logic                       wr_en_q, wr_en_d;
  logic                       stall_q, stall_d;
  logic                       load_full, load_ready, load_hs;
  logic                       pacer_pulse, pacer_busy;
  logic                       in_dump;

  assign load_full  = (word_cnt_q == WORDS);
  assign load_ready = (state_q == ST_LOAD_WAIT) && !load_full && !i_load_end;
  assign load_hs    = load_ready && i_load_valid;

  ram_write_pacer #(.WRITE_GAP(WRITE_GAP)) u_pacer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (load_hs),
    .o_pulse (pacer_pulse),
    .o_busy  (pacer_busy)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    dump_idx_d  = dump_idx_q;
    dump_cnt_d  = dump_cnt_q;
    lat_d       = lat_q;
    end_seen_d  = end_seen_q;
    wdata_d     = wdata_q;
    dump_data_d = dump_data_q;
    dump_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_load_start) begin
          state_d    = ST_LOAD_WAIT;
          end_seen_d = 1'b0;
        end else if (i_dump_start) begin
          state_d    = ST_DUMP_ADDR;
          dump_idx_d = '0;
          dump_cnt_d = clamp_count(i_dump_count, WORDS);
        end
      end
      ST_LOAD_WAIT: begin
        if (i_load_end) begin
          state_d = ST_IDLE;
        end else if (load_hs) begin
          wdata_d = i_load_data;
          state_d = ST_LOAD_PULSE;
        end
      end
      ST_LOAD_PULSE: begin
        if (i_load_end) end_seen_d = 1'b1;
        if (word_cnt_q != WORDS) word_cnt_d = word_cnt_q + NB_WORD_COUNT'(1);
        if (WRITE_GAP == 0)
          state_d = (end_seen_q || i_load_end) ? ST_IDLE : ST_LOAD_WAIT;
        else
          state_d = ST_LOAD_GAP;
      end
      ST_LOAD_GAP: begin
        if (i_load_end) end_seen_d = 1'b1;
        if (!pacer_busy)
          state_d = (end_seen_q || i_load_end) ? ST_IDLE : ST_LOAD_WAIT;
      end
      ST_DUMP_ADDR: begin
        if (dump_cnt_q == '0) begin
          dump_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (READ_LATENCY == 0) begin
          dump_data_d = i_ram_read_data;
          state_d     = ST_DUMP_OUT;
        end else begin
          lat_d   = '0;
          state_d = ST_DUMP_WAIT;
        end
      end
      ST_DUMP_WAIT: begin
        if (lat_q == NB_LAT'(READ_LATENCY - 1)) begin
          dump_data_d = i_ram_read_data;
          state_d     = ST_DUMP_OUT;
        end else begin
          lat_d = lat_q + NB_LAT'(1);
        end
      end
      ST_DUMP_OUT: begin
        if (i_dump_ready) begin
          dump_idx_d = dump_idx_q + NB_WORD_COUNT'(1);
          if ((dump_idx_q + NB_WORD_COUNT'(1)) == dump_cnt_q) begin
            dump_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DUMP_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered from the next state so they align with it.
    wr_en_d      = state_d inside {ST_LOAD_WAIT, ST_LOAD_PULSE, ST_LOAD_GAP};
    stall_d      = (state_d != ST_IDLE);
    dump_valid_d = (state_d == ST_DUMP_OUT);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      dump_idx_q   <= '0;
      dump_cnt_q   <= '0;
      lat_q        <= '0;
      end_seen_q   <= 1'b0;
      wdata_q      <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      dump_idx_q   <= dump_idx_d;
      dump_cnt_q   <= dump_cnt_d;
      lat_q        <= lat_d;
      end_seen_q   <= end_seen_d;
      wdata_q      <= wdata_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      wr_en_q      <= wr_en_d;
      stall_q      <= stall_d;
    end
  end

  assign in_dump = state_q inside {ST_DUMP_ADDR, ST_DUMP_WAIT, ST_DUMP_OUT};

  assign o_ram_read_address    = in_dump ? NB_ADDRESS'(dump_idx_q * WORD_STRIDE) : i_fetch_address;
  assign o_fetch_data          = (state_q == ST_IDLE) ? i_ram_read_data : '0;
  assign o_fetch_stall         = stall_q;
  assign o_load_ready          = load_ready;
  assign o_load_full           = load_full;
  assign o_word_count          = word_cnt_q;
  assign o_dump_data           = dump_data_q;
  assign o_dump_valid          = dump_valid_q;
  assign o_dump_done           = dump_done_q;
  assign o_ram_write_data      = wdata_q;
  assign o_ram_write_enable    = wr_en_q;
  assign o_ram_write_data_next = pacer_pulse;

`ifdef RAM_ACCESS_STATS_EN
  logic [15:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (stall_q && stall_cyc_q != 16'hFFFF) stall_cyc_d = stall_cyc_q + 16'd1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) stall_cyc_q <= '0;
    else          stall_cyc_q <= stall_cyc_d;
  end

  assign o_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller with a small append-pointer RAM model.
module tb_ram_access_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_end, load_valid, dump_start, dump_ready;
  logic [31:0] load_data;
  logic [6:0]  dump_count;
  logic [7:0]  fetch_addr;
  logic        load_ready, load_full, dump_valid, dump_done, fetch_stall;
  logic        ram_we, ram_wdn;
  logic [31:0] dump_data, fetch_data, ram_wdata, ram_rdata;
  logic [6:0]  word_count;
  logic [7:0]  ram_raddr;
`ifdef RAM_ACCESS_STATS_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  ram_access_controller dut (
    .i_clock               (clk),
    .i_reset               (rst_n),
    .i_load_start          (load_start),
    .i_load_end            (load_end),
    .i_load_data           (load_data),
    .i_load_valid          (load_valid),
    .o_load_ready          (load_ready),
    .o_load_full           (load_full),
    .i_dump_start          (dump_start),
    .i_dump_count          (dump_count),
    .o_dump_data           (dump_data),
    .o_dump_valid          (dump_valid),
    .i_dump_ready          (dump_ready),
    .o_dump_done           (dump_done),
    .i_fetch_address       (fetch_addr),
    .o_fetch_data          (fetch_data),
    .o_fetch_stall         (fetch_stall),
    .o_word_count          (word_count),
    .o_ram_read_address    (ram_raddr),
    .o_ram_write_data      (ram_wdata),
    .o_ram_write_enable    (ram_we),
    .o_ram_write_data_next (ram_wdn),
`ifdef RAM_ACCESS_STATS_EN
    .o_stall_cycles        (stall_cycles),
`endif
    .i_ram_read_data       (ram_rdata)
  );

  // RAM model: one-cycle read latency, writes append at an internal pointer.
  logic [31:0] mem [0:63];
  logic [5:0]  wptr;
  always @(posedge clk) begin
    if (!rst_n) begin
      ram_rdata <= 32'h0;
      wptr      <= 6'd0;
    end else begin
      ram_rdata <= mem[ram_raddr[7:2]];
      if (ram_we && ram_wdn) begin
        mem[wptr] <= ram_wdata;
        wptr      <= wptr + 6'd1;
      end
    end
  end

  int cyc = 0, npulse = 0, last_pulse = 0, last_gap = 0, ndone = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wdn) begin
      if (npulse > 0) last_gap <= cyc - last_pulse;
      last_pulse <= cyc;
      npulse     <= npulse + 1;
    end
    if (dump_done) ndone <= ndone + 1;
  end

  typedef struct { logic [31:0] data; logic [6:0] exp_count; } load_vec_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } dump_vec_t;
  load_vec_t lv [4];
  dump_vec_t dv [4];

  int checks = 0, errors = 0;
  int n, nw, bad, ndone0;
  logic seen, stable, got_done;
  logic [31:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] d);
    int k = 0;
    load_valid = 1'b1;
    load_data  = d;
    while (!load_ready && k < 20) begin tick(); k++; end
    chk("load_ready_wait", {31'b0, load_ready}, 32'd1);
    tick();
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!load_ready && k < 20) begin tick(); k++; end
    chk("session_ready_wait", {31'b0, load_ready}, 32'd1);
  endtask

  task automatic end_session();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    lv[0] = '{32'hAABBCC55, 7'd1};
    lv[1] = '{32'h11223344, 7'd2};
    lv[2] = '{32'h89ABCDEF, 7'd3};
    lv[3] = '{32'h00AA00BB, 7'd4};
    for (int i = 0; i < 4; i++) dv[i] = '{8'(i * 4), lv[i].data};

    rst_n = 1'b0; load_start = 0; load_end = 0; load_valid = 0; load_data = 0;
    dump_start = 0; dump_ready = 0; dump_count = 0; fetch_addr = 8'h24;
    tick(); tick();
    chk("rst_stall", {31'b0, fetch_stall}, 0);
    chk("rst_we", {31'b0, ram_we}, 0);
    chk("rst_wdn", {31'b0, ram_wdn}, 0);
    chk("rst_ready", {31'b0, load_ready}, 0);
    chk("rst_full", {31'b0, load_full}, 0);
    chk("rst_dvalid", {31'b0, dump_valid}, 0);
    chk("rst_done", {31'b0, dump_done}, 0);
    chk("rst_count", {25'b0, word_count}, 0);
    chk("rst_raddr", {24'b0, ram_raddr}, 32'h24);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_ddata", dump_data, 0);
    chk("rst_fdata", fetch_data, 0);

    rst_n = 1'b1;
    tick();
    fetch_addr = 8'h30;
    #1;
    chk("idle_raddr", {24'b0, ram_raddr}, 32'h30);

    // Session 1: two back-to-back words, then end from LOAD_WAIT
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("s1_stall", {31'b0, fetch_stall}, 1);
    chk("s1_we", {31'b0, ram_we}, 1);
    chk("s1_ready", {31'b0, load_ready}, 1);
    for (int i = 0; i < 2; i++) load_word(lv[i].data);
    load_valid = 1'b0;
    wait_ready();
    load_end = 1'b1; #1;
    chk("end_blocks_ready", {31'b0, load_ready}, 0);
    tick(); load_end = 1'b0;
    chk("s1_we_off", {31'b0, ram_we}, 0);
    chk("s1_stall_off", {31'b0, fetch_stall}, 0);
    chk("s1_count", {25'b0, word_count}, {25'b0, lv[1].exp_count});
    chk("s1_pulses", npulse, 2);
    chk("s1_pulse_spacing", last_gap, 8);

    // Session 2: load_end (and a dropped dump_start) during the gap
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_word(lv[2].data);
    load_valid = 1'b0;
    tick();
    load_end = 1'b1; dump_start = 1'b1; dump_count = 7'd5;
    tick();
    load_end = 1'b0; dump_start = 1'b0;
    chk("gap_we_held", {31'b0, ram_we}, 1);
    n = 0;
    while (ram_we && n < 20) begin tick(); n++; end
    chk("gap_to_idle_cycles", n, 5);
    chk("s2_count", {25'b0, word_count}, {25'b0, lv[2].exp_count});
    chk("s2_pulses", npulse, 3);
    seen = 1'b0;
    repeat (6) begin tick(); seen |= dump_valid | fetch_stall; end
    chk("dump_start_dropped", {31'b0, seen}, 0);

    // Session 3
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_word(lv[3].data);
    load_valid = 1'b0;
    wait_ready();
    end_session();
    chk("s3_count", {25'b0, word_count}, {25'b0, lv[3].exp_count});
    chk("s3_not_full", {31'b0, load_full}, 0);

    // Dump 4 words with a slow consumer
    ndone0 = ndone;
    dump_count = 7'd4; dump_start = 1'b1; tick(); dump_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!dump_valid && n < 10) begin tick(); n++; end
      chk("dump_valid_wait", {31'b0, dump_valid}, 1);
      chk("dump_addr", {24'b0, ram_raddr}, {24'b0, dv[i].addr});
      chk("dump_data", dump_data, dv[i].data);
      stable = 1'b1;
      repeat (3) begin
        tick();
        if (!dump_valid || dump_data !== dv[i].data) stable = 1'b0;
      end
      chk("dump_hold", {31'b0, stable}, 1);
      dump_ready = 1'b1; tick(); dump_ready = 1'b0;
    end
    chk("dump4_done", {31'b0, dump_done}, 1);
    chk("dump4_valid_off", {31'b0, dump_valid}, 0);
    tick();
    chk("dump4_done_once", ndone - ndone0, 1);
    fetch_addr = 8'h04;
    tick();
    chk("idle_fetch_data", fetch_data, 32'h11223344);

    // Fill to 64 words
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 60; i++) load_word(32'h1000_0000 + i);
    seen = 1'b0;
    repeat (12) begin tick(); seen |= load_ready; end
    chk("full_ready_low", {31'b0, seen}, 0);
    chk("full_flag", {31'b0, load_full}, 1);
    chk("full_count", {25'b0, word_count}, 64);
    chk("full_pulses", npulse, 64);
    load_valid = 1'b0;
    end_session();
    chk("full_we_off", {31'b0, ram_we}, 0);

    // Dump count 100 clamps to 64
    ndone0 = ndone; nw = 0; bad = 0; got_done = 1'b0;
    dump_ready = 1'b1; dump_count = 7'd100; dump_start = 1'b1; tick(); dump_start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (dump_valid) begin
        exp_w = (nw < 4) ? dv[nw].data : 32'h1000_0000 + 32'(nw - 4);
        if (dump_data !== exp_w || ram_raddr !== 8'(nw * 4)) bad++;
        nw++;
      end
      if (dump_done) begin got_done = 1'b1; break; end
    end
    dump_ready = 1'b0;
    chk("clamp_words", nw, 64);
    chk("clamp_data_errs", bad, 0);
    chk("clamp_done", {31'b0, got_done}, 1);

    // Zero-length dump
    dump_count = 7'd0; dump_start = 1'b1; tick(); dump_start = 1'b0;
    chk("zero_stall", {31'b0, fetch_stall}, 1);
    chk("zero_valid", {31'b0, dump_valid}, 0);
    tick();
    chk("zero_done", {31'b0, dump_done}, 1);
    chk("zero_valid2", {31'b0, dump_valid}, 0);

    // Simultaneous start pulses: load wins
    dump_count = 7'd2; load_start = 1'b1; dump_start = 1'b1; tick();
    load_start = 1'b0; dump_start = 1'b0;
    chk("simul_load_we", {31'b0, ram_we}, 1);
    seen = 1'b0;
    repeat (5) begin tick(); seen |= dump_valid; end
    end_session();
    repeat (5) begin tick(); seen |= dump_valid | fetch_stall; end
    chk("simul_no_dump", {31'b0, seen}, 0);
    chk("simul_count", {25'b0, word_count}, 64);

    // Async reset in the middle of DUMP_OUT
    dump_count = 7'd3; dump_start = 1'b1; tick(); dump_start = 1'b0;
    n = 0;
    while (!dump_valid && n < 10) begin tick(); n++; end
    chk("rmid_valid_pre", {31'b0, dump_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_valid", {31'b0, dump_valid}, 0);
    chk("rmid_stall", {31'b0, fetch_stall}, 0);
    chk("rmid_count", {25'b0, word_count}, 0);
    chk("rmid_raddr", {24'b0, ram_raddr}, 32'h04);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rmid_after_valid", {31'b0, dump_valid}, 0);
    chk("rmid_after_wdn", {31'b0, ram_wdn}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
